oam_dma_ctrl: RTL and testbench
===============================

Name: oam_dma_ctrl

Overview:
- Sprite-DMA sequencer and bus owner for the CPU bus.
- Snoops CPU writes to the DMA register. On a trigger, it stalls the cpu via a ready line and takes the shared address/data bus. It then copies 256 bytes from CPU page P (P00..PFF) to the PPU OAM data port.
- Sits between cpu and the system bus decoder. It is the only block that can take bus ownership away from the cpu.

Parameters:
- DMA_REG_ADDR, 16'h4014, CPU write address that triggers DMA; the written byte is the source page.
- OAM_DATA_ADDR, 16'h2004, destination address for every DMA write.
- XFER_LEN, 256, bytes per transfer. The counter width is fixed at 8 bits, so only 256 is legal.

Ports:
- clk  in  1  system clock. All state updates on negedge clk, the same edge as cpu.
- rst_n  in  1  synchronous, active-low reset.
- cpu_addr  in  16  cpu address.
- cpu_rw  in  1  cpu direction, 1 = read.
- cpu_wdata  in  8  cpu write data.
- cpu_rdata  out  8  read data to cpu, always equal to bus_rdata.
- cpu_rdy  out  1  0 = cpu must hold state (stall).
- bus_addr  out  16  system bus address.
- bus_rw  out  1  system bus direction.
- bus_wdata  out  8  system bus write data.
- bus_rdata  in  8  system bus read data.
- dma_active  out  1  high while DMA owns the bus.

Behaviour:
- Reset (rst_n=0 at an edge) gives:
  - state=IDLE, parity=0, cnt=0, page=0, latch=0.
  - cpu_rdy=1, dma_active=0, bus fully passthrough.
- parity flop:
  - Toggles every clock after reset; 0 = get cycle, 1 = put cycle.
  - Not affected by DMA.
- IDLE:
  - bus_addr/bus_rw/bus_wdata = cpu_addr/cpu_rw/cpu_wdata (combinational).
  - A cycle with cpu_rw=0 and cpu_addr=DMA_REG_ADDR latches page=cpu_wdata and moves to HALT.
  - That trigger write still reaches the bus unchanged.
- HALT (1 cycle):
  - cpu_rdy=0, dma_active=1.
  - bus_addr=cpu_addr, bus_rw=1 (dummy read); no bus write may occur.
  - Next state is READ if the next cycle's parity is 0, else ALIGN.
- ALIGN (1 cycle): same bus drive as HALT, then READ.
- READ:
  - bus_addr={page,cnt}, bus_rw=1.
  - latch<=bus_rdata at the edge ending the cycle; then WRITE.
  - READ always lands on parity=0.
- WRITE:
  - bus_addr=OAM_DATA_ADDR, bus_rw=0, bus_wdata=latch.
  - cnt<=cnt+1 (8-bit wrap).
  - If cnt was 8'hFF, go to IDLE; else go to READ.
- Total stall: 513 cycles if the trigger write lands on parity=0 (the HALT cycle then has parity=1), 514 otherwise.
- cpu_rdy returns to 1 in the first cycle after the final WRITE.
- cnt is 0 on entry to HALT, and is 0 again on exit via wrap.
- Page FF is legal; the source address never exceeds {page,8'hFF}, i.e. no carry into the page.
- Writes to DMA_REG_ADDR while not IDLE: impossible from the cpu (stalled). They are ignored; page is not reloaded.
- Reset mid-transfer: the next cycle is IDLE and passthrough with cpu_rdy=1. The partially written OAM is left as is.
- cpu_rdata = bus_rdata in all states. The stalled cpu ignores it.
- DMC/APU DMA is out of scope; this block is the sole bus master besides cpu.

Decomposition:
- Shared package dma_pkg holds:
  - typedef enum logic[2:0] dma_state_t {IDLE, HALT, ALIGN, READ, WRITE}.
  - localparams for DMA_REG_ADDR and OAM_DATA_ADDR defaults.
- One natural sub-module: cpu_bus_mux. It is purely combinational and selects between the cpu fields and the DMA-generated addr/rw/wdata on dma_active.
- The FSM, counter, page, latch and parity flops stay in oam_dma_ctrl.

Test Plan:
- Passthrough: after reset, cpu reads 16'h8000 and writes 8'h5A to 16'h0300. Required: bus mirrors both exactly, cpu_rdy=1, dma_active=0.
- Even trigger: write 8'h02 to 16'h4014 on parity=0, with RAM 0x0200+i=i^8'hA5. Required:
  - 513 stall cycles.
  - 256 writes to 16'h2004 with data i^8'hA5 in order.
  - cpu_rdy=1 on cycle 514.
- Odd trigger: same transfer, triggered on parity=1. Required: ALIGN present, 514 stall cycles, identical data sequence.
- Page FF: trigger with 8'hFF. Required: source addresses 16'hFF00..16'hFFFF, last read 16'hFFFF, no access to 16'h0000.
- Reset mid-DMA: assert rst_n=0 for one cycle after 100 writes. Required:
  - Next cycle cpu_rdy=1, bus passthrough, cnt=0.
  - A new trigger performs a full 256-byte transfer.
- Back-to-back: retrigger in the first cycle after completion. Required: second DMA starts normally, and the first cpu instruction between the two DMAs executes.

Source files
------------

// File: rtl/dma_pkg.sv
// Shared types and default addresses for the sprite-DMA sequencer.
// States are ordered so that IDLE is the all-zero encoding.
package dma_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    HALT  = 3'd1,
    ALIGN = 3'd2,
    READ  = 3'd3,
    WRITE = 3'd4
  } dma_state_t;

  localparam logic [15:0] DMA_REG_ADDR_DEF  = 16'h4014;
  localparam logic [15:0] OAM_DATA_ADDR_DEF = 16'h2004;

endpackage

// File: rtl/cpu_bus_mux.sv
// Bus owner select: cpu fields pass straight through unless DMA owns the bus.
// Purely combinational, zero latency; no backpressure of its own.
module cpu_bus_mux
  import dma_pkg::*;
(
  input  logic        dma_active,
  input  logic [15:0] cpu_addr,
  input  logic        cpu_rw,
  input  logic [7:0]  cpu_wdata,
  input  logic [15:0] dma_addr,
  input  logic        dma_rw,
  input  logic [7:0]  dma_wdata,
  output logic [15:0] bus_addr,
  output logic        bus_rw,
  output logic [7:0]  bus_wdata
);

  assign bus_addr  = dma_active ? dma_addr  : cpu_addr;
  assign bus_rw    = dma_active ? dma_rw    : cpu_rw;
  assign bus_wdata = dma_active ? dma_wdata : cpu_wdata;

endmodule

// File: rtl/oam_dma_ctrl.sv
// Sprite-DMA sequencer: snoops cpu writes to the DMA register, stalls the cpu via cpu_rdy
// and copies one 256-byte page to the OAM data port, one byte per get/put cycle pair.
module oam_dma_ctrl
  import dma_pkg::*;
#(
  parameter logic [15:0] DMA_REG_ADDR  = DMA_REG_ADDR_DEF,
  parameter logic [15:0] OAM_DATA_ADDR = OAM_DATA_ADDR_DEF,
  parameter int          XFER_LEN      = 256
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] cpu_addr,
  input  logic        cpu_rw,
  input  logic [7:0]  cpu_wdata,
  output logic [7:0]  cpu_rdata,
  output logic        cpu_rdy,
  output logic [15:0] bus_addr,
  output logic        bus_rw,
  output logic [7:0]  bus_wdata,
  input  logic [7:0]  bus_rdata,
  output logic        dma_active
);

  // The byte counter is 8 bits wide, so the final index is always 8'hFF.
  localparam logic [7:0] LAST_IDX = 8'(XFER_LEN - 1);

  dma_state_t  state_q, state_d;
  logic        parity_q, parity_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [7:0]  page_q, page_d;
  logic [7:0]  latch_q, latch_d;

  logic [15:0] dma_addr;
  logic        dma_rw;
  logic [7:0]  dma_wdata;

  always_comb begin
    state_d   = state_q;
    parity_d  = ~parity_q;
    cnt_d     = cnt_q;
    page_d    = page_q;
    latch_d   = latch_q;
    // HALT/ALIGN issue a dummy read at whatever address the stalled cpu holds.
    dma_addr  = cpu_addr;
    dma_rw    = 1'b1;
    dma_wdata = cpu_wdata;

    case (state_q)
      IDLE: begin
        if (!cpu_rw && (cpu_addr == DMA_REG_ADDR)) begin
          page_d  = cpu_wdata;
          cnt_d   = 8'h00;
          state_d = HALT;
        end
      end
      HALT: begin
        // READ must land on a get cycle; parity_q=1 now means the next cycle is a get.
        state_d = parity_q ? READ : ALIGN;
      end
      ALIGN: begin
        state_d = READ;
      end
      READ: begin
        dma_addr = {page_q, cnt_q};
        latch_d  = bus_rdata;
        state_d  = WRITE;
      end
      WRITE: begin
        dma_addr  = OAM_DATA_ADDR;
        dma_rw    = 1'b0;
        dma_wdata = latch_q;
        cnt_d     = cnt_q + 8'h01;
        state_d   = (cnt_q == LAST_IDX) ? IDLE : READ;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(negedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      parity_q <= 1'b0;
      cnt_q    <= 8'h00;
      page_q   <= 8'h00;
      latch_q  <= 8'h00;
    end else begin
      state_q  <= state_d;
      parity_q <= parity_d;
      cnt_q    <= cnt_d;
      page_q   <= page_d;
      latch_q  <= latch_d;
    end
  end

  assign dma_active = (state_q != IDLE);
  assign cpu_rdy    = ~dma_active;
  assign cpu_rdata  = bus_rdata;

  cpu_bus_mux u_mux (
    .dma_active (dma_active),
    .cpu_addr   (cpu_addr),
    .cpu_rw     (cpu_rw),
    .cpu_wdata  (cpu_wdata),
    .dma_addr   (dma_addr),
    .dma_rw     (dma_rw),
    .dma_wdata  (dma_wdata),
    .bus_addr   (bus_addr),
    .bus_rw     (bus_rw),
    .bus_wdata  (bus_wdata)
  );

endmodule

// File: tb/tb_oam_dma_ctrl.sv
// Bench for oam_dma_ctrl: RAM model on the bus, scoreboard of expected OAM bytes and
// source addresses filled at trigger time and drained by a bus monitor.
module tb_oam_dma_ctrl;

  localparam logic [15:0] DMA_REG = 16'h4014;
  localparam logic [15:0] OAM_REG = 16'h2004;
  localparam logic [15:0] CPU_PC  = 16'h8000;

  logic        clk = 1'b1;
  logic        rst_n = 1'b0;
  logic [15:0] cpu_addr = 16'h0000;
  logic        cpu_rw = 1'b1;
  logic [7:0]  cpu_wdata = 8'h00;
  logic [7:0]  cpu_rdata;
  logic        cpu_rdy;
  logic [15:0] bus_addr;
  logic        bus_rw;
  logic [7:0]  bus_wdata;
  logic [7:0]  bus_rdata;
  logic        dma_active;

  logic [7:0]  mem [0:65535];
  logic        tb_par = 1'b0;

  logic [7:0]  exp_dat [$];
  logic [15:0] exp_adr [$];

  int          n_chk = 0;
  int          n_err = 0;
  int          wr_cnt = 0;
  int          zero_hits = 0;
  logic [15:0] prev_addr = 16'h0000;
  logic        prev_rw = 1'b1;

  always #5 clk = ~clk;

  assign bus_rdata = mem[bus_addr];

  // Get/put parity as the cpu sees it: 0 in the first cycle after reset.
  always @(negedge clk) tb_par <= rst_n ? ~tb_par : 1'b0;

  oam_dma_ctrl dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cpu_addr   (cpu_addr),
    .cpu_rw     (cpu_rw),
    .cpu_wdata  (cpu_wdata),
    .cpu_rdata  (cpu_rdata),
    .cpu_rdy    (cpu_rdy),
    .bus_addr   (bus_addr),
    .bus_rw     (bus_rw),
    .bus_wdata  (bus_wdata),
    .bus_rdata  (bus_rdata),
    .dma_active (dma_active)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %0h want %0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
    #1;
  endtask

  task automatic smp();
    #3;
  endtask

  // Each OAM write must carry the next expected byte and follow a read of its source.
  always @(posedge clk) begin
    if (dma_active && !bus_rw && bus_addr == OAM_REG) begin
      wr_cnt++;
      if (exp_dat.size() == 0) begin
        chk("oam_extra", 32'd1, 32'd0);
      end else begin
        chk("oam_dat", bus_wdata, exp_dat.pop_front());
        chk("src_adr", {prev_rw, prev_addr}, {1'b1, exp_adr.pop_front()});
      end
    end
    if (dma_active && bus_addr == 16'h0000) zero_hits++;
    prev_addr = bus_addr;
    prev_rw   = bus_rw;
  end

  task automatic push_page(input logic [7:0] page);
    for (int i = 0; i < 256; i++) begin
      exp_adr.push_back({page, 8'(i)});
      exp_dat.push_back(mem[{page, 8'(i)}]);
    end
  endtask

  // Trigger on the requested parity, run to completion; returns inside the first free cycle.
  task automatic do_dma(input logic [7:0] page, input logic par, input int exp_stall,
                        input int exp_wait);
    int waits;
    int stall;
    waits = 0;
    stall = 0;
    while (tb_par != par && waits < 4) begin
      cyc();
      waits++;
    end
    if (exp_wait >= 0) chk("retrig_wait", waits, exp_wait);
    push_page(page);
    wr_cnt    = 0;
    cpu_addr  = DMA_REG;
    cpu_rw    = 1'b0;
    cpu_wdata = page;
    smp();
    chk("trig_bus", {cpu_rdy, dma_active, bus_addr, bus_rw, bus_wdata},
        {1'b1, 1'b0, DMA_REG, 1'b0, page});
    cyc();
    cpu_addr = CPU_PC;
    cpu_rw   = 1'b1;
    smp();
    while (stall < 700) begin
      if (cpu_rdy) break;
      if (stall == 0)
        chk("halt_bus", {dma_active, bus_rw, bus_addr}, {1'b1, 1'b1, CPU_PC});
      if (stall == 1)
        chk("step2_adr", bus_addr, par ? CPU_PC : {page, 8'h00});
      stall++;
      cyc();
      smp();
    end
    chk("stall", stall, exp_stall);
    chk("wr_cnt", wr_cnt, 256);
    chk("q_empty", exp_dat.size(), 0);
    chk("after_bus", {dma_active, bus_addr, bus_rw}, {1'b0, CPU_PC, 1'b1});
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
    for (int i = 0; i < 256; i++) begin
      mem[16'h0200 + i] = 8'(i) ^ 8'hA5;
      mem[16'h0300 + i] = ~8'(i);
      mem[16'hFF00 + i] = 8'(i * 3) ^ 8'h5A;
    end
    mem[CPU_PC] = 8'h3C;

    // Reset state
    cyc();
    cyc();
    smp();
    chk("rst_out", {cpu_rdy, dma_active, bus_addr, bus_rw}, {1'b1, 1'b0, 16'h0000, 1'b1});
    cyc();
    rst_n = 1'b1;

    // Passthrough read and write
    cpu_addr = CPU_PC;
    cpu_rw   = 1'b1;
    smp();
    chk("pt_rd", {cpu_rdy, dma_active, bus_addr, bus_rw, cpu_rdata},
        {1'b1, 1'b0, CPU_PC, 1'b1, 8'h3C});
    cyc();
    cpu_addr  = 16'h0300;
    cpu_rw    = 1'b0;
    cpu_wdata = 8'h5A;
    smp();
    chk("pt_wr", {cpu_rdy, dma_active, bus_addr, bus_rw, bus_wdata},
        {1'b1, 1'b0, 16'h0300, 1'b0, 8'h5A});
    cyc();
    cpu_addr = CPU_PC;
    cpu_rw   = 1'b1;

    // Even and odd triggers
    do_dma(8'h02, 1'b0, 513, -1);
    cyc();
    do_dma(8'h02, 1'b1, 514, -1);
    cyc();

    // Page FF must never carry into page 00
    zero_hits = 0;
    do_dma(8'hFF, 1'b0, 513, -1);
    chk("no_zero", zero_hits, 0);
    cyc();

    // Reset after 100 OAM writes
    push_page(8'h02);
    wr_cnt    = 0;
    cpu_addr  = DMA_REG;
    cpu_rw    = 1'b0;
    cpu_wdata = 8'h02;
    cyc();
    cpu_addr = CPU_PC;
    cpu_rw   = 1'b1;
    for (int k = 0; k < 400; k++) begin
      if (wr_cnt >= 100) break;
      cyc();
    end
    chk("pre_rst_wr", wr_cnt, 100);
    rst_n = 1'b0;
    cyc();
    rst_n = 1'b1;
    exp_dat.delete();
    exp_adr.delete();
    smp();
    chk("mid_rst", {cpu_rdy, dma_active, bus_addr, bus_rw}, {1'b1, 1'b0, CPU_PC, 1'b1});
    do_dma(8'h02, tb_par, tb_par ? 514 : 513, -1);

    // Back-to-back: retrigger in the first free cycle
    do_dma(8'h03, 1'b0, 513, 0);

    cyc();
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
